// File: rtl/com_rx_parse.sv
// com_rx_parse: frames the link UART byte stream into command packets
// (0x55 0xAA TYPE LEN payload CHK), writes payload bytes to the command RAM,
// and presents each accepted packet to console_com via a ready/done handshake.
module com_rx_parse #(
  parameter int MAX_LEN = 16,
  parameter int TIMEOUT = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       fs_com_read,
  input  logic       fd_com_read,
  output logic [3:0] com_btype,
  output logic [7:0] com_len,
  output logic       ram_wen,
  output logic [7:0] ram_addr,
  output logic [7:0] ram_data,
  output logic [7:0] err_cnt
);

  localparam int IW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [IW-1:0] IDLE_LAST = IW'(TIMEOUT - 1);
  localparam logic [7:0]    LEN_MAX   = 8'(MAX_LEN);

  typedef enum logic [2:0] {
    S_HEAD0, S_HEAD1, S_TYPE, S_LEN, S_DATA, S_CHK, S_DONE, S_ERR
  } state_t;

  state_t        r_state;
  state_t        w_next_state;

  logic [3:0]    r_type_sh;   // TYPE held until the checksum is confirmed
  logic [7:0]    r_len_sh;    // LEN held until the checksum is confirmed
  logic [7:0]    r_idx;       // payload byte index
  logic [7:0]    r_xor;       // running checksum
  logic [IW-1:0] r_idle;      // idle cycles since the last byte

  logic          r_fs_com_read;
  logic [3:0]    r_com_btype;
  logic [7:0]    r_com_len;
  logic          r_ram_wen;
  logic [7:0]    r_ram_addr;
  logic [7:0]    r_ram_data;
  logic [7:0]    r_err_cnt;

  logic          w_timed;
  logic          w_timeout;
  logic          w_wr_en;
  logic          w_accept;
  logic          w_err_inc;
  logic          w_fs_next;

  // Timeout only runs while a packet is being received, and a byte arriving
  // on the expiry cycle always wins over the timeout.
  assign w_timed   = (r_state == S_TYPE) || (r_state == S_LEN) ||
                     (r_state == S_DATA) || (r_state == S_CHK);
  assign w_timeout = w_timed && !rx_valid && (r_idle == IDLE_LAST);

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_HEAD0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of block evaluation order.
      r_state <= w_next_state;
    end
  end

  // Next-state logic
  always_comb begin
    // NOTE: default first so every path assigns the signal and no latch is inferred.
    w_next_state = r_state;
    case (r_state)
      S_HEAD0: begin
        if (rx_valid && rx_data == 8'h55) w_next_state = S_HEAD1;
      end
      S_HEAD1: begin
        if (rx_valid) begin
          if (rx_data == 8'hAA)      w_next_state = S_TYPE;
          else if (rx_data != 8'h55) w_next_state = S_HEAD0;
        end
      end
      S_TYPE: begin
        if (rx_valid) w_next_state = (rx_data[7:4] != 4'h0) ? S_ERR : S_LEN;
      end
      S_LEN: begin
        if (rx_valid) begin
          if (rx_data > LEN_MAX)     w_next_state = S_ERR;
          else if (rx_data == 8'h00) w_next_state = S_CHK;
          else                       w_next_state = S_DATA;
        end
      end
      S_DATA: begin
        if (rx_valid && r_idx == r_len_sh - 8'd1) w_next_state = S_CHK;
      end
      S_CHK: begin
        if (rx_valid) w_next_state = (rx_data == r_xor) ? S_DONE : S_ERR;
      end
      S_DONE: begin
        if (fd_com_read) w_next_state = S_HEAD0;
      end
      S_ERR: begin
        w_next_state = S_HEAD0;
      end
      default: w_next_state = S_HEAD0;
    endcase
    if (w_timeout) w_next_state = S_ERR;
  end

  // Output decode: values that get registered on the next edge
  always_comb begin
    w_wr_en   = (r_state == S_DATA) && rx_valid;
    w_accept  = (r_state == S_CHK) && rx_valid && (rx_data == r_xor);
    w_err_inc = (r_state == S_ERR) && (r_err_cnt != 8'hFF);
    w_fs_next = (w_next_state == S_DONE);
  end

  // Packet bookkeeping: shadows, payload index, checksum and idle counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_type_sh <= 4'h0;
      r_len_sh  <= 8'h00;
      r_idx     <= 8'h00;
      r_xor     <= 8'h00;
      r_idle    <= '0;
    end else begin
      if (r_state == S_TYPE && rx_valid) r_type_sh <= rx_data[3:0];
      if (r_state == S_LEN && rx_valid) begin
        r_len_sh <= rx_data;
        r_idx    <= 8'h00;
      end
      if (w_wr_en) r_idx <= r_idx + 8'd1;

      if (r_state == S_HEAD1) begin
        r_xor <= 8'h00;
      end else if (rx_valid && (r_state == S_TYPE || r_state == S_LEN ||
                                r_state == S_DATA)) begin
        r_xor <= r_xor ^ rx_data;
      end

      if (!w_timed || rx_valid) r_idle <= '0;
      else                      r_idle <= r_idle + 1'b1;
    end
  end

  // Registered outputs: RAM write port, handshake, packet descriptor, error count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_fs_com_read <= 1'b0;
      r_com_btype   <= 4'h0;
      r_com_len     <= 8'h00;
      r_ram_wen     <= 1'b0;
      r_ram_addr    <= 8'h00;
      r_ram_data    <= 8'h00;
      r_err_cnt     <= 8'h00;
    end else begin
      r_fs_com_read <= w_fs_next;
      r_ram_wen     <= w_wr_en;
      if (w_wr_en) begin
        r_ram_addr <= r_idx;
        r_ram_data <= rx_data;
      end
      if (w_accept) begin
        r_com_btype <= r_type_sh;
        r_com_len   <= r_len_sh;
      end
      if (w_err_inc) r_err_cnt <= r_err_cnt + 8'd1;
    end
  end

  assign fs_com_read = r_fs_com_read;
  assign com_btype   = r_com_btype;
  assign com_len     = r_com_len;
  assign ram_wen     = r_ram_wen;
  assign ram_addr    = r_ram_addr;
  assign ram_data    = r_ram_data;
  assign err_cnt     = r_err_cnt;

endmodule

// File: tb/tb_com_rx_parse.sv
// tb_com_rx_parse: directed self-checking bench for com_rx_parse.
module tb_com_rx_parse;

  localparam int MAX_LEN = 16;
  localparam int TIMEOUT = 1000;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       fs_com_read;
  logic       fd_com_read;
  logic [3:0] com_btype;
  logic [7:0] com_len;
  logic       ram_wen;
  logic [7:0] ram_addr;
  logic [7:0] ram_data;
  logic [7:0] err_cnt;

  int n_checks = 0;
  int n_errors = 0;

  logic [7:0] wr_addr[$];
  logic [7:0] wr_data[$];
  logic [7:0] frame[$];

  com_rx_parse #(.MAX_LEN(MAX_LEN), .TIMEOUT(TIMEOUT)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx_data     (rx_data),
    .rx_valid    (rx_valid),
    .fs_com_read (fs_com_read),
    .fd_com_read (fd_com_read),
    .com_btype   (com_btype),
    .com_len     (com_len),
    .ram_wen     (ram_wen),
    .ram_addr    (ram_addr),
    .ram_data    (ram_data),
    .err_cnt     (err_cnt)
  );

  always #5 clk = ~clk;

  // Record every RAM write seen by the bench
  always @(negedge clk) begin
    if (rst_n && ram_wen) begin
      wr_addr.push_back(ram_addr);
      wr_data.push_back(ram_data);
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Called at a negedge; strobes one byte and returns at the following negedge
  task automatic send_byte(input logic [7:0] b);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0;
    rx_data  = 8'h00;
  endtask

  task automatic send_frame();
    foreach (frame[i]) send_byte(frame[i]);
  endtask

  task automatic clear_writes();
    wr_addr.delete();
    wr_data.delete();
  endtask

  task automatic handshake(input string tag);
    fd_com_read = 1'b1;
    @(negedge clk);
    check({tag, "_fs_fall"}, fs_com_read, 1'b0);
    fd_com_read = 1'b0;
  endtask

  initial begin
    rst_n       = 1'b0;
    rx_data     = 8'h00;
    rx_valid    = 1'b0;
    fd_com_read = 1'b0;
    #1;
    check("rst_fs", fs_com_read, 1'b0);
    check("rst_btype", com_btype, 4'h0);
    check("rst_len", com_len, 8'h00);
    check("rst_wen", ram_wen, 1'b0);
    check("rst_err", err_cnt, 8'h00);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // 1: three-byte payload; checksum 02^03^11^22^33 = 01
    clear_writes();
    frame = '{8'h55, 8'hAA, 8'h02, 8'h03, 8'h11, 8'h22, 8'h33, 8'h01};
    send_frame();
    check("t1_fs", fs_com_read, 1'b1);
    check("t1_btype", com_btype, 4'h2);
    check("t1_len", com_len, 8'h03);
    check("t1_nwr", wr_addr.size(), 3);
    if (wr_addr.size() == 3) begin
      check("t1_a0", wr_addr[0], 8'h00);
      check("t1_d0", wr_data[0], 8'h11);
      check("t1_a1", wr_addr[1], 8'h01);
      check("t1_d1", wr_data[1], 8'h22);
      check("t1_a2", wr_addr[2], 8'h02);
      check("t1_d2", wr_data[2], 8'h33);
    end
    repeat (5) @(negedge clk);
    check("t1_fs_held", fs_com_read, 1'b1);
    check("t1_btype_held", com_btype, 4'h2);
    handshake("t1");
    check("t1_btype_after", com_btype, 4'h2);

    // 2: empty payload, good and bad checksum
    clear_writes();
    frame = '{8'h55, 8'hAA, 8'h01, 8'h00, 8'h01};
    send_frame();
    check("t2_fs", fs_com_read, 1'b1);
    check("t2_btype", com_btype, 4'h1);
    check("t2_len", com_len, 8'h00);
    check("t2_nwr", wr_addr.size(), 0);
    handshake("t2");
    frame = '{8'h55, 8'hAA, 8'h01, 8'h00, 8'h00};
    send_frame();
    @(negedge clk);
    check("t2_bad_fs", fs_com_read, 1'b0);
    check("t2_bad_err", err_cnt, 8'h01);

    // 3: resync on repeated 0x55, then illegal TYPE
    frame = '{8'h55, 8'h55, 8'hAA, 8'h03, 8'h00, 8'h03};
    send_frame();
    check("t3_fs", fs_com_read, 1'b1);
    check("t3_btype", com_btype, 4'h3);
    handshake("t3");
    frame = '{8'h55, 8'hAA, 8'h13, 8'h00, 8'h13};
    send_frame();
    @(negedge clk);
    check("t3_bad_fs", fs_com_read, 1'b0);
    check("t3_bad_err", err_cnt, 8'h02);
    check("t3_bad_btype", com_btype, 4'h3);

    // 4: timeout inside DATA, then a good frame
    frame = '{8'h55, 8'hAA, 8'h02, 8'h05};
    send_frame();
    repeat (TIMEOUT - 1) @(negedge clk);
    check("t4_err_before", err_cnt, 8'h02);
    repeat (2) @(negedge clk);
    check("t4_err_after", err_cnt, 8'h03);
    check("t4_fs", fs_com_read, 1'b0);
    clear_writes();
    frame = '{8'h55, 8'hAA, 8'h07, 8'h01, 8'h5A, 8'h5C};
    send_frame();
    check("t4_next_fs", fs_com_read, 1'b1);
    check("t4_next_btype", com_btype, 4'h7);
    check("t4_next_len", com_len, 8'h01);
    check("t4_next_nwr", wr_addr.size(), 1);
    if (wr_addr.size() == 1) check("t4_next_d0", wr_data[0], 8'h5A);
    handshake("t4");

    // 5: bytes arriving while DONE are discarded
    frame = '{8'h55, 8'hAA, 8'h04, 8'h01, 8'hAB, 8'hAE};
    send_frame();
    check("t5_fs", fs_com_read, 1'b1);
    check("t5_btype", com_btype, 4'h4);
    frame = '{8'h55, 8'hAA, 8'h01, 8'h00, 8'h01};
    send_frame();
    @(negedge clk);
    check("t5_fs_hold", fs_com_read, 1'b1);
    check("t5_btype_hold", com_btype, 4'h4);
    check("t5_len_hold", com_len, 8'h01);
    check("t5_err_hold", err_cnt, 8'h03);
    handshake("t5");
    frame = '{8'h55, 8'hAA, 8'h05, 8'h00, 8'h05};
    send_frame();
    check("t5_next_fs", fs_com_read, 1'b1);
    check("t5_next_btype", com_btype, 4'h5);
    handshake("t5n");

    // 6: asynchronous reset in the middle of the payload
    frame = '{8'h55, 8'hAA, 8'h02, 8'h04, 8'h11, 8'h22};
    send_frame();
    check("t6_wen_pre", ram_wen, 1'b1);
    check("t6_addr_pre", ram_addr, 8'h01);
    rst_n = 1'b0;
    #1;
    check("t6_wen", ram_wen, 1'b0);
    check("t6_addr", ram_addr, 8'h00);
    check("t6_data", ram_data, 8'h00);
    check("t6_err", err_cnt, 8'h00);
    check("t6_btype", com_btype, 4'h0);
    check("t6_len", com_len, 8'h00);
    check("t6_fs", fs_com_read, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    clear_writes();
    // checksum 06^02^A1^B2 = 17
    frame = '{8'h55, 8'hAA, 8'h06, 8'h02, 8'hA1, 8'hB2, 8'h17};
    send_frame();
    check("t6_next_fs", fs_com_read, 1'b1);
    check("t6_next_btype", com_btype, 4'h6);
    check("t6_next_len", com_len, 8'h02);
    check("t6_next_nwr", wr_addr.size(), 2);
    if (wr_addr.size() == 2) begin
      check("t6_next_a1", wr_addr[1], 8'h01);
      check("t6_next_d1", wr_data[1], 8'hB2);
    end
    handshake("t6");

    // Error counter saturation over 300 rejected frames
    frame = '{8'h55, 8'hAA, 8'h10};
    for (int i = 0; i < 300; i++) begin
      send_frame();
      @(negedge clk);
      if (i == 253) check("sat_254", err_cnt, 8'hFE);
    end
    check("sat_300", err_cnt, 8'hFF);
    check("sat_fs", fs_com_read, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
